if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline: owns the PC, drives the instruction-memory request handshake and the IF/ID pipeline register. It sits directly upstream of the ID-stage control/hazard unit. It consumes that unit's `stall`, `branch`, `jump` and `jr` outputs to hold or redirect fetch. Instructions fetched down a wrong path are cancelled, because the pipeline has no delay slot. Instruction memory may insert wait states; a 2-state skid buffer plus drain logic keeps the request stable.

---
 rtl/if_stage.sv | 119 +++++++++++
 tb/tb_if_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request handshake and the IF/ID register.
// A one-entry buffer absorbs a fetch that lands during a stall; DRAIN retires a request cancelled mid-wait.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] br_target,
    input  logic [31:0] jr_target,
    input  logic [25:0] jaddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic [31:0] pc
);
    typedef enum logic [1:0] {S_FETCH, S_BUF, S_DRAIN} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_buf;
    logic [31:0] r_buf_pc4;
    logic        r_id_valid;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc4;

    logic        w_redir;
    logic [31:0] w_tgt;
    logic [31:0] w_pc4;

    // A branch that arrives together with a stall is ignored.
    assign w_redir = branch & ~stall;
    assign w_pc4   = r_pc + 32'd4;

    always_comb begin
        w_tgt = br_target;
        if (jr)
            w_tgt = jr_target;
        else if (jump)
            w_tgt = {r_id_pc4[31:28], jaddr, 2'b00};
    end

    assign imem_req  = ~rst & (r_state != S_BUF);
    assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign id_valid  = r_id_valid;
    assign id_inst   = r_id_inst;
    assign id_pc4    = r_id_pc4;
    assign pc        = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= 32'd0;
            r_buf        <= 32'd0;
            r_buf_pc4    <= 32'd0;
            r_id_valid   <= 1'b0;
            r_id_inst    <= 32'd0;
            r_id_pc4     <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redir) begin
                        r_pc       <= w_tgt;
                        r_id_valid <= 1'b0;
                        // Outstanding request must stay on the bus until memory answers.
                        if (!imem_ready) begin
                            r_drain_addr <= r_pc;
                            r_state      <= S_DRAIN;
                        end
                    end else if (!stall) begin
                        if (imem_ready) begin
                            r_id_inst  <= imem_rdata;
                            r_id_pc4   <= w_pc4;
                            r_id_valid <= 1'b1;
                            r_pc       <= w_pc4;
                        end else begin
                            r_id_valid <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        r_buf     <= imem_rdata;
                        r_buf_pc4 <= w_pc4;
                        r_pc      <= w_pc4;
                        r_state   <= S_BUF;
                    end
                end
                S_BUF: begin
                    if (w_redir) begin
                        r_pc       <= w_tgt;
                        r_id_valid <= 1'b0;
                        r_state    <= S_FETCH;
                    end else if (!stall) begin
                        r_id_inst  <= r_buf;
                        r_id_pc4   <= r_buf_pc4;
                        r_id_valid <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready)
                        r_state <= S_FETCH;
                    if (w_redir)
                        r_pc <= w_tgt;
                    if (!stall)
                        r_id_valid <= 1'b0;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: program-order scoreboard of fetched addresses plus directed timing checks,
// against a wait-state memory model that returns the address as data.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, jr = 1'b0;
    logic [31:0] br_target = 32'd0, jr_target = 32'd0;
    logic [25:0] jaddr = 26'd0;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst, id_pc4, pc;

    int          checks = 0, errors = 0, n_pop = 0;
    int          lat = 0;
    logic [7:0]  wcnt = 8'd0;
    logic [31:0] q[$];
    logic [31:0] tail = 32'd0, exp_tgt = 32'd0, cur_pc4 = 32'd0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jump(jump), .jr(jr),
        .br_target(br_target), .jr_target(jr_target), .jaddr(jaddr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .id_valid(id_valid), .id_inst(id_inst),
        .id_pc4(id_pc4), .pc(pc)
    );

    always #5 clk = ~clk;

    // Memory answers after 'lat' wait cycles; data is only meaningful with ready.
    assign imem_ready = imem_req && (int'(wcnt) >= lat);
    assign imem_rdata = imem_ready ? imem_addr : 32'hDEAD_BEEF;
    always @(posedge clk) wcnt <= (!imem_req || imem_ready) ? 8'd0 : wcnt + 8'd1;

    logic        p_rst, p_stall, p_redir, p_req, p_ready, p_idv;
    logic [31:0] p_addr, p_tgt;
    always @(posedge clk) begin
        p_rst   <= rst;
        p_stall <= stall;
        p_redir <= branch && !stall && !rst;
        p_req   <= imem_req;
        p_ready <= imem_ready;
        p_addr  <= imem_addr;
        p_tgt   <= exp_tgt;
        p_idv   <= id_valid;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (q.size() < 4) begin
            tail = tail + 32'd4;
            q.push_back(tail);
        end
    endtask

    // Drive one cycle of ID-stage controls; a taken redirect restarts program order at the target.
    task automatic drv(input logic st, input logic br, input logic jp, input logic j_r,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [25:0] ja);
        stall = st; branch = br; jump = jp; jr = j_r;
        br_target = bt; jr_target = jt; jaddr = ja;
        if (br && !st) begin
            if (j_r)     exp_tgt = jt;
            else if (jp) exp_tgt = (cur_pc4 & 32'hF000_0000) | (32'(ja) * 32'd4);
            else         exp_tgt = bt;
            q.delete();
            q.push_back(exp_tgt);
            tail = exp_tgt;
        end
        topup();
        @(negedge clk);
    endtask

    task automatic idle_c();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
    endtask

    task automatic do_rst(input int n);
        rst = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
        q.delete();
        q.push_back(RESET_PC);
        tail = RESET_PC;
        topup();
        #1 chk("req_in_rst", imem_req, 0);
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every non-stalled, non-redirected edge that leaves a valid IF/ID entry must be
    // the next address in program order.
    initial begin
        int idle = 0;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (p_rst) begin
                cur_pc4 = 32'd0;
                idle = 0;
                chk("rst_valid", id_valid, 0);
                chk("rst_pc", pc, RESET_PC);
                chk("rst_pc4", id_pc4, 0);
                chk("rst_inst", id_inst, 0);
            end else begin
                if (p_req && !p_ready) begin
                    chk("req_held", imem_req, 1);
                    chk("addr_held", imem_addr, p_addr);
                end
                if (p_stall) begin
                    chk("stall_valid", id_valid, p_idv);
                    chk("stall_pc4", id_pc4, cur_pc4);
                end else if (p_redir) begin
                    chk("redir_bubble", id_valid, 0);
                    chk("redir_pc", pc, p_tgt);
                    idle = 0;
                end else if (id_valid) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_empty act=%h exp=none", id_pc4);
                    end else begin
                        e = q.pop_front();
                        chk("sb_inst", id_inst, e);
                        chk("sb_pc4", id_pc4, e + 32'd4);
                        cur_pc4 = e + 32'd4;
                        n_pop++;
                    end
                    idle = 0;
                end else begin
                    idle++;
                    if (idle >= 40) begin
                        checks++; errors++;
                        $display("FAIL fetch_timeout act=%0d idle cycles exp<40", idle);
                        idle = 0;
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_rst(2);
        // sequential fetch, zero-wait
        chk("seq_a0", imem_addr, 32'h0); idle_c();
        chk("seq_a4", imem_addr, 32'h4); chk("seq_v0", id_valid, 1); idle_c();
        chk("seq_a8", imem_addr, 32'h8); idle_c();
        chk("seq_a12", imem_addr, 32'hC); chk("seq_id8", id_inst, 32'h8);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        chk("buf_req0", imem_req, 0); drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        chk("buf_req1", imem_req, 0); drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        chk("buf_req2", imem_req, 0); chk("stall_id8", id_inst, 32'h8); idle_c();
        chk("resume_a16", imem_addr, 32'h10); chk("resume_id12", id_inst, 32'hC); idle_c();
        chk("resume_id16", id_inst, 32'h10); chk("resume_v", id_valid, 1);
        // branch redirect
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 26'd0);
        chk("br_bubble", id_valid, 0); chk("br_addr", imem_addr, 32'h40); idle_c();
        chk("br_inst", id_inst, 32'h40); chk("br_pc4", id_pc4, 32'h44);
        // jump / jr targets
        drv(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h1000_0000, 26'd0);
        idle_c();
        chk("j_id", id_pc4, 32'h1000_0004);
        drv(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 26'h100);
        chk("j_pc", pc, 32'h1000_0400);
        drv(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'h200, 26'h3FF);
        chk("jr_pc", pc, 32'h200); idle_c(); idle_c();
        // wait-state drain
        drv(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h1C, 26'd0);
        chk("d_a1c", imem_addr, 32'h1C); idle_c();
        lat = 3; #1;
        chk("d_a20", imem_addr, 32'h20); chk("d_wait", imem_ready, 0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'd0, 26'd0);
        chk("d_hold1", imem_addr, 32'h20); chk("d_v", id_valid, 0); idle_c();
        chk("d_hold2", imem_addr, 32'h20); idle_c();
        chk("d_hold3", imem_addr, 32'h20); chk("d_ready", imem_ready, 1);
        lat = 0; idle_c();
        chk("d_a80", imem_addr, 32'h80); idle_c(); idle_c();
        // pc wrap
        drv(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFF8, 26'd0);
        chk("w_a8", imem_addr, 32'hFFFF_FFF8); idle_c();
        chk("w_ac", imem_addr, 32'hFFFF_FFFC); idle_c();
        chk("wrap_addr", imem_addr, 32'h0); chk("wrap_pc", pc, 32'h0); idle_c(); idle_c();
        // reset while buffer is full
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        chk("f_inbuf", imem_req, 0);
        do_rst(1);
        chk("f_pc", pc, RESET_PC); chk("f_v", id_valid, 0); chk("f_a", imem_addr, RESET_PC);
        idle_c(); idle_c(); idle_c();
        // reset while draining
        lat = 3; #1;
        chk("g_wait", imem_ready, 0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'd0, 26'd0);
        chk("g_drain", imem_addr, 32'hC); chk("g_pc", pc, 32'h300);
        do_rst(1);
        lat = 0;
        chk("g_pc0", pc, RESET_PC); chk("g_v", id_valid, 0); chk("g_a", imem_addr, RESET_PC);
        idle_c(); idle_c();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic st, br, jp, j_r;
            if ($urandom_range(0, 99) == 0) begin
                do_rst(int'($urandom_range(1, 2)));
                continue;
            end
            if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(0, 3));
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            jp  = ($urandom_range(0, 1) == 1);
            j_r = ($urandom_range(0, 2) == 0);
            drv(st, br, jp, j_r, $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC, 26'($urandom()));
        end
        idle_c(); idle_c();
        chk("progress", n_pop > 500, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
